// File: rtl/pc_seq_if.sv
// -----------------------------------------------------------------------------
// pc_seq_if
// Control/status bundle between the instruction decoder and the program-counter
// sequencer. The decoder side (master) drives the control requests and observes
// the sequencer state. The sequencer side (slave) does the opposite.
//
// Signals:
//   stall     decoder -> seq   hold pc and RAS this cycle
//   halt      decoder -> seq   request transition to HALTED
//   br_taken  decoder -> seq   relative branch by sign-extended br_off
//   br_off    decoder -> seq   signed branch offset, OFF_W bits
//   jmp       decoder -> seq   absolute jump to jmp_tgt
//   call      decoder -> seq   absolute jump to jmp_tgt, push pc+1
//   ret       decoder -> seq   pop return address into pc
//   jmp_tgt   decoder -> seq   absolute target for jmp/call
//   pc        seq -> decoder   current program counter (registered)
//   ras_cnt   seq -> decoder   number of valid return-address entries
//   ras_ovf   seq -> decoder   sticky: call issued while RAS full
//   ras_unf   seq -> decoder   sticky: ret issued while RAS empty
//   halted    seq -> decoder   high while in HALTED
// -----------------------------------------------------------------------------
interface pc_seq_if #(
    parameter int PC_W      = 8,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4
);
    logic                               stall;
    logic                               halt;
    logic                               br_taken;
    logic [OFF_W-1:0]                   br_off;
    logic                               jmp;
    logic                               call;
    logic                               ret;
    logic [PC_W-1:0]                    jmp_tgt;
    logic [PC_W-1:0]                    pc;
    logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt;
    logic                               ras_ovf;
    logic                               ras_unf;
    logic                               halted;

    modport master (
        output stall, halt, br_taken, br_off, jmp, call, ret, jmp_tgt,
        input  pc, ras_cnt, ras_ovf, ras_unf, halted
    );

    modport slave (
        input  stall, halt, br_taken, br_off, jmp, call, ret, jmp_tgt,
        output pc, ras_cnt, ras_ovf, ras_unf, halted
    );
endinterface

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq
// Parameterised program-counter sequencer for the single-cycle core.
// Supports sequential increment, PC-relative branch, absolute jump, call/return
// through a circular hardware return-address stack (RAS), stall and a
// RUN/HALTED state machine. Every output is taken straight from a register.
//
// Ports:
//   clk    in   clock, all state updates on the rising edge
//   reset  in   asynchronous active-high reset (pc=RESET_PC, RAS empty, RUN)
//   bus    slave side of pc_seq_if (controls in, pc/RAS status out)
//
// Next-pc priority in RUN (first match wins):
//   halt > stall > ret > call > jmp > br_taken > increment
// -----------------------------------------------------------------------------
module pc_seq #(
    parameter int          PC_W      = 8,
    parameter int          OFF_W     = 5,
    parameter int          RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic    clk,
    input  logic    reset,
    pc_seq_if.slave bus
);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // State registers
    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [CNT_W-1:0]   r_cnt;
    logic [PTR_W-1:0]   r_ptr;      // next write slot; most recent entry is r_ptr-1
    logic               r_ovf;
    logic               r_unf;
    logic [PC_W-1:0]    r_ras [RAS_DEPTH];

    // Next-state values
    state_t             w_state_next;
    logic [PC_W-1:0]    w_pc_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [PTR_W-1:0]   w_ptr_next;
    logic               w_ovf_next;
    logic               w_unf_next;
    logic               w_push;

    // Helpers
    logic [PC_W-1:0]        w_pc_plus1;
    logic signed [PC_W-1:0] w_off_ext;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic [PTR_W-1:0]       w_ptr_dec;
    logic [PC_W-1:0]        w_ras_top;

    assign w_pc_plus1 = r_pc + PC_W'(1);
    // Assigning a signed operand to a wider signed net sign-extends it.
    assign w_off_ext  = $signed(bus.br_off);

    // Pointer arithmetic is modulo RAS_DEPTH so non-power-of-two depths work.
    assign w_ptr_inc  = (r_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec  = (r_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : r_ptr - PTR_W'(1);
    assign w_ras_top  = r_ras[w_ptr_dec];

    // -------------------------------------------------------------------------
    // Next-state / datapath decision
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        w_ptr_next   = r_ptr;
        w_ovf_next   = r_ovf;
        w_unf_next   = r_unf;
        w_push       = 1'b0;

        if (r_state == ST_RUN) begin
            if (bus.halt) begin
                w_state_next = ST_HALTED;
            end else if (bus.stall) begin
                // hold everything
            end else if (bus.ret) begin
                if (r_cnt != '0) begin
                    w_pc_next  = w_ras_top;
                    w_cnt_next = r_cnt - CNT_W'(1);
                    w_ptr_next = w_ptr_dec;
                end else begin
                    // Underflow: fall through to the next instruction.
                    w_pc_next  = w_pc_plus1;
                    w_unf_next = 1'b1;
                end
            end else if (bus.call) begin
                w_pc_next  = bus.jmp_tgt;
                w_push     = 1'b1;
                w_ptr_next = w_ptr_inc;
                // When full, the write slot holds the oldest entry, so the
                // push overwrites it and the count saturates.
                if (r_cnt == CNT_W'(RAS_DEPTH)) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end else if (bus.jmp) begin
                w_pc_next = bus.jmp_tgt;
            end else if (bus.br_taken) begin
                w_pc_next = r_pc + w_off_ext;
            end else begin
                w_pc_next = w_pc_plus1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= PC_W'(RESET_PC);
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
            r_ptr   <= w_ptr_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
        end
    end

    // RAS storage: contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_ptr] <= w_pc_plus1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.pc      = r_pc;
    assign bus.ras_cnt = r_cnt;
    assign bus.ras_ovf = r_ovf;
    assign bus.ras_unf = r_unf;
    assign bus.halted  = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq
// Directed self-checking bench for pc_seq (PC_W=8, OFF_W=5, RAS_DEPTH=4,
// RESET_PC=0). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so each check sees the result of the previous edge.
// -----------------------------------------------------------------------------
module tb_pc_seq;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    pc_seq_if #(.PC_W(8), .OFF_W(5), .RAS_DEPTH(4)) bus ();

    pc_seq #(
        .PC_W      (8),
        .OFF_W     (5),
        .RAS_DEPTH (4),
        .RESET_PC  (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic st, input logic hl, input logic br,
                         input logic [4:0] off, input logic jp, input logic cl,
                         input logic rt, input logic [7:0] tgt);
        bus.stall    = st;
        bus.halt     = hl;
        bus.br_taken = br;
        bus.br_off   = off;
        bus.jmp      = jp;
        bus.call     = cl;
        bus.ret      = rt;
        bus.jmp_tgt  = tgt;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 0, 0, 0, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t pc=0x%02h ras_cnt=%0d ovf=%0b unf=%0b halted=%0b",
                 $time, bus.pc, bus.ras_cnt, bus.ras_ovf, bus.ras_unf, bus.halted);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",     32'(bus.pc),      32'h00);
        chk("rst_cnt",    32'(bus.ras_cnt), 32'd0);
        chk("rst_ovf",    32'(bus.ras_ovf), 32'd0);
        chk("rst_unf",    32'(bus.ras_unf), 32'd0);
        chk("rst_halted", 32'(bus.halted),  32'd0);
        #2 reset = 1'b0;

        // ---- reset mid-run: build pc=0x2A, ras_cnt=2, ras_ovf=1 ----
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h20);
        repeat (5) tick();
        chk("pre_ovf_cnt", 32'(bus.ras_cnt), 32'd4);
        drive(0, 0, 0, 5'd0, 0, 0, 1, 8'h00);
        repeat (2) tick();
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'h2A);
        tick();
        idle();
        chk("mid_pc",  32'(bus.pc),      32'h2A);
        chk("mid_cnt", 32'(bus.ras_cnt), 32'd2);
        chk("mid_ovf", 32'(bus.ras_ovf), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_pc",     32'(bus.pc),      32'h00);
        chk("async_cnt",    32'(bus.ras_cnt), 32'd0);
        chk("async_ovf",    32'(bus.ras_ovf), 32'd0);
        chk("async_halted", 32'(bus.halted),  32'd0);
        #1 reset = 1'b0;
        tick();
        chk("inc_after_rst", 32'(bus.pc), 32'h01);

        // ---- wrap and branch ----
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'hFF);
        tick();
        idle();
        tick();
        chk("fwd_wrap", 32'(bus.pc), 32'h00);
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'h10);
        tick();
        drive(0, 0, 1, 5'b11101, 0, 0, 0, 8'h00);
        tick();
        chk("br_back", 32'(bus.pc), 32'h0D);
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'h01);
        tick();
        drive(0, 0, 1, 5'b11101, 0, 0, 0, 8'h00);
        tick();
        chk("br_back_wrap", 32'(bus.pc), 32'hFE);
        drive(0, 0, 1, 5'b00101, 0, 0, 0, 8'h00);
        tick();
        chk("br_fwd_wrap", 32'(bus.pc), 32'h03);

        // ---- call/return nesting ----
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'h05);
        tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h40);
        tick();
        chk("call1_pc", 32'(bus.pc), 32'h40);
        idle();
        tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h80);
        tick();
        chk("call2_pc",  32'(bus.pc),      32'h80);
        chk("call2_cnt", 32'(bus.ras_cnt), 32'd2);
        drive(0, 0, 0, 5'd0, 0, 0, 1, 8'h00);
        tick();
        chk("ret1_pc", 32'(bus.pc), 32'h42);
        tick();
        chk("ret2_pc",  32'(bus.pc),      32'h06);
        chk("ret2_cnt", 32'(bus.ras_cnt), 32'd0);
        chk("nest_ovf", 32'(bus.ras_ovf), 32'd0);
        chk("nest_unf", 32'(bus.ras_unf), 32'd0);

        // ---- RAS overflow / underflow ----
        drive(0, 0, 0, 5'd0, 1, 0, 0, 8'h00);
        tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h10); tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h20); tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h30); tick();
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h40); tick();
        chk("full_cnt", 32'(bus.ras_cnt), 32'd4);
        chk("full_ovf", 32'(bus.ras_ovf), 32'd0);
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h50); tick();
        chk("ovf_pc",  32'(bus.pc),      32'h50);
        chk("ovf_cnt", 32'(bus.ras_cnt), 32'd4);
        chk("ovf_flag", 32'(bus.ras_ovf), 32'd1);
        drive(0, 0, 0, 5'd0, 0, 0, 1, 8'h00);
        tick(); chk("pop1", 32'(bus.pc), 32'h41);
        tick(); chk("pop2", 32'(bus.pc), 32'h31);
        tick(); chk("pop3", 32'(bus.pc), 32'h21);
        tick(); chk("pop4", 32'(bus.pc), 32'h11);
        chk("pop4_cnt", 32'(bus.ras_cnt), 32'd0);
        chk("pop4_unf", 32'(bus.ras_unf), 32'd0);
        tick();
        chk("unf_pc",   32'(bus.pc),      32'h12);
        chk("unf_flag", 32'(bus.ras_unf), 32'd1);
        chk("unf_cnt",  32'(bus.ras_cnt), 32'd0);

        // ---- priority and stall ----
        drive(1, 0, 0, 5'd0, 1, 1, 0, 8'h77);
        tick();
        chk("stall_pc",  32'(bus.pc),      32'h12);
        chk("stall_cnt", 32'(bus.ras_cnt), 32'd0);
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h60);
        tick();
        drive(0, 0, 0, 5'd0, 1, 1, 1, 8'h99);
        tick();
        chk("prio_ret_pc",  32'(bus.pc),      32'h13);
        chk("prio_ret_cnt", 32'(bus.ras_cnt), 32'd0);
        drive(0, 0, 1, 5'b00101, 1, 1, 0, 8'h70);
        tick();
        chk("prio_call_pc",  32'(bus.pc),      32'h70);
        chk("prio_call_cnt", 32'(bus.ras_cnt), 32'd1);
        drive(0, 0, 1, 5'b11101, 1, 0, 0, 8'h88);
        tick();
        chk("prio_jmp_pc", 32'(bus.pc), 32'h88);
        drive(0, 0, 0, 5'd0, 0, 0, 1, 8'h00);
        tick();
        chk("prio_pop_pc", 32'(bus.pc), 32'h14);
        drive(0, 0, 0, 5'd0, 0, 1, 1, 8'h50);
        tick();
        chk("prio_unf_pc",  32'(bus.pc),      32'h15);
        chk("prio_unf_cnt", 32'(bus.ras_cnt), 32'd0);

        // ---- halt ----
        drive(0, 0, 0, 5'd0, 0, 1, 0, 8'h33);
        tick();
        drive(1, 1, 0, 5'd0, 0, 0, 0, 8'h00);
        tick();
        chk("halt_flag", 32'(bus.halted),  32'd1);
        chk("halt_pc",   32'(bus.pc),      32'h33);
        chk("halt_cnt",  32'(bus.ras_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 1, 5'b00011, 1, i[0], i[1], 8'(8'hA0 + i));
            tick();
            chk("frozen_pc",  32'(bus.pc),      32'h33);
            chk("frozen_cnt", 32'(bus.ras_cnt), 32'd1);
        end
        chk("frozen_halted", 32'(bus.halted),  32'd1);
        chk("frozen_ovf",    32'(bus.ras_ovf), 32'd1);
        chk("frozen_unf",    32'(bus.ras_unf), 32'd1);

        idle();
        #2 reset = 1'b1;
        #1;
        chk("unhalt_pc",     32'(bus.pc),      32'h00);
        chk("unhalt_halted", 32'(bus.halted),  32'd0);
        chk("unhalt_cnt",    32'(bus.ras_cnt), 32'd0);
        chk("unhalt_ovf",    32'(bus.ras_ovf), 32'd0);
        chk("unhalt_unf",    32'(bus.ras_unf), 32'd0);
        #1 reset = 1'b0;
        tick();
        chk("run_again_pc", 32'(bus.pc), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parameterised program-counter sequencer for the single-cycle core. Successor to the fixed 6-bit increment/jump counter.
- Adds:
  - configurable PC width
  - PC-relative branches
  - call/return with a hardware return-address stack (RAS)
  - stall
  - a RUN/HALTED state machine
- Feeds the instruction-memory address and receives control from the decoder.

Parameters:
- PC_W, 8, width of pc and jump targets; all PC arithmetic is modulo 2^PC_W.
- OFF_W, 5, width of signed branch offset (two's complement), OFF_W <= PC_W.
- RAS_DEPTH, 4, number of return-address entries, >= 2.
- RESET_PC, 0, pc value loaded on reset.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- stall, in, 1, hold pc and RAS this cycle.
- halt, in, 1, request transition to HALTED.
- br_taken, in, 1, relative branch: pc <= pc + sext(br_off).
- br_off, in, OFF_W, signed branch offset relative to current pc.
- jmp, in, 1, absolute jump to jmp_tgt.
- call, in, 1, absolute jump to jmp_tgt and push pc+1 on RAS.
- ret, in, 1, pop RAS top into pc.
- jmp_tgt, in, PC_W, absolute target for jmp/call.
- pc, out, PC_W, current program counter (registered).
- ras_cnt, out, $clog2(RAS_DEPTH+1), valid RAS entries.
- ras_ovf, out, 1, sticky: call issued with RAS full.
- ras_unf, out, 1, sticky: ret issued with RAS empty.
- halted, out, 1, high in HALTED state.

Behaviour:
- Reset (async, immediate, any state or mid-operation):
  - pc=RESET_PC, ras_cnt=0, ras_ovf=0, ras_unf=0, halted=0, state=RUN.
  - RAS entry contents are don't-care.
- States: RUN, HALTED.
  - RUN -> HALTED on any edge where halt=1. Stall does not block halt.
  - HALTED -> RUN only via reset.
- In HALTED: pc, RAS, ras_cnt and flags frozen; all control inputs ignored.
- RUN next-pc priority, evaluated each edge (first match wins):
  1. halt: pc holds, RAS unchanged, enter HALTED.
  2. stall: pc holds, RAS unchanged.
  3. ret with ras_cnt>0: pc <= RAS top; ras_cnt--.
  4. ret with ras_cnt==0: pc <= pc+1; ras_unf <= 1; RAS unchanged.
  5. call: pc <= jmp_tgt; push (pc+1) mod 2^PC_W.
     - ras_cnt<RAS_DEPTH: ras_cnt++.
     - ras_cnt==RAS_DEPTH: oldest entry discarded (circular overwrite), ras_cnt stays RAS_DEPTH, ras_ovf <= 1.
  6. jmp: pc <= jmp_tgt.
  7. br_taken: pc <= pc + sign_extend(br_off) modulo 2^PC_W (wraps both directions).
  8. otherwise: pc <= pc+1 (wraps 2^PC_W-1 -> 0).
- Multiple simultaneous controls resolve strictly by the priority above. Lower-priority requests are dropped, not queued.
- Latency: one cycle. The decision made with inputs at edge N is visible on pc after edge N.
- Outputs: pc, ras_cnt, ras_ovf, ras_unf and halted are all registered; no combinational path from inputs to outputs.
- The RAS is LIFO. Implementation: circular buffer with top pointer; pop after overflow returns the most recent RAS_DEPTH addresses in reverse push order.
- ras_ovf/ras_unf are cleared only by reset.

Test Plan:
- Reset mid-run: pc=0x2A, ras_cnt=2, ras_ovf=1; assert reset between clock edges -> pc=0, ras_cnt=0, ras_ovf=0, halted=0 immediately, without waiting for a clock edge.
- Wrap and branch:
  - Forward wrap: pc=0xFF, no control -> pc=0x00.
  - Backward branch: pc=0x10, br_taken, br_off=5'b11101 (-3) -> pc=0x0D.
  - Backward wrap: pc=0x01, br_off=-3 -> pc=0xFE.
- Call/return nesting:
  - From pc=0x05 call 0x40; from pc=0x41 call 0x80 -> ras_cnt=2.
  - ret -> pc=0x42, then ret -> pc=0x06; ras_cnt=0, no flags set.
- RAS overflow/underflow (RAS_DEPTH=4):
  - 5 calls from pcs 0x00, 0x10, 0x20, 0x30, 0x40 -> ras_ovf=1, ras_cnt=4.
  - 4 rets -> pc sequence 0x41, 0x31, 0x21, 0x11.
  - 5th ret -> pc=0x12, ras_unf=1.
- Priority and stall:
  - stall + jmp -> pc holds.
  - ret + call + jmp with ras_cnt=1 -> ret taken.
  - call + jmp + br_taken -> call taken with push.
  - jmp + br_taken -> pc=jmp_tgt.
- Halt:
  - halt with stall=1 at pc=0x33 -> halted=1, pc stays 0x33.
  - Then jmp/call/ret for 10 cycles -> no change to pc, ras_cnt or flags.
  - reset -> RUN, pc=0.
